// File: rtl/if_fetch.sv
// Instruction-fetch unit: owns the PC, issues one ROM request per cycle and
// queues tagged instruction words (2 entries) toward decode; jumps flush everything.
module if_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_send_valid_o,
    input  logic              pc_receive_ready_i,
    input  logic [DATA_W-1:0] inst_data_i,
    input  logic              inst_valid_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i
);

    localparam int DEPTH = 2;

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
    logic              inflight_reg, inflight_next;
    logic [1:0]        count_reg, count_next;
    logic              wr_ptr_reg, wr_ptr_next;
    logic              rd_ptr_reg, rd_ptr_next;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  wr_en;

    logic              accept;
    logic              pop;
    logic              push;
    logic [2:0]        credit;

    // Handshake and credit: the queue plus the in-flight word may never exceed two,
    // so a captured response always has a free slot.
    always_comb begin
        inst_valid_o    = rst_n & ~jump_en_i & (count_reg != 2'd0);
        pop             = inst_valid_o & inst_ready_i;
        credit          = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
        pc_send_valid_o = rst_n & ~jump_en_i & (credit < 3'd2);
        accept          = pc_send_valid_o & pc_receive_ready_i;
        push            = inflight_reg & inst_valid_i & ~jump_en_i;
    end

    always_comb begin
        pc_next       = pc_reg;
        req_pc_next   = req_pc_reg;
        inflight_next = inflight_reg;
        count_next    = count_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        if (jump_en_i) begin
            // Pointers realign so the first post-jump push lands at the head.
            pc_next       = {jump_addr_i[ADDR_W-1:2], 2'b00};
            inflight_next = 1'b0;
            count_next    = 2'd0;
            wr_ptr_next   = 1'b0;
            rd_ptr_next   = 1'b0;
        end else begin
            if (accept) begin
                pc_next     = pc_reg + ADDR_W'(4);
                req_pc_next = pc_reg;
            end
            inflight_next = accept;
            if (push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            count_next = count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            req_pc_reg   <= '0;
            inflight_reg <= 1'b0;
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            req_pc_reg   <= req_pc_next;
            inflight_reg <= inflight_next;
            count_reg    <= count_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push & (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    // Entries are cleared on reset so the head reads as zero while in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    addr_mem[i] <= req_pc_reg;
                    data_mem[i] <= inst_data_i;
                end
            end
        end
    end

    assign pc_o        = pc_reg;
    assign inst_o      = data_mem[rd_ptr_reg];
    assign inst_addr_o = addr_mem[rd_ptr_reg];

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed phases then random traffic, checked every cycle
// against a queue-based reference model and a behavioural registered ROM.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_o;
    logic        pc_send_valid_o;
    logic        pc_receive_ready_i;
    logic [31:0] inst_data_i;
    logic        inst_valid_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    always #5 clk = ~clk;

    if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pc_o               (pc_o),
        .pc_send_valid_o    (pc_send_valid_o),
        .pc_receive_ready_i (pc_receive_ready_i),
        .inst_data_i        (inst_data_i),
        .inst_valid_i       (inst_valid_i),
        .jump_en_i          (jump_en_i),
        .jump_addr_i        (jump_addr_i),
        .inst_o             (inst_o),
        .inst_addr_o        (inst_addr_o),
        .inst_valid_o       (inst_valid_o),
        .inst_ready_i       (inst_ready_i)
    );

    // Reference model state: expected queue of {addr, data}, PC, in-flight request.
    logic [63:0] q[$];
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_addr;
    bit          m_in_reset;
    bit          m_known;

    // ROM model state, driven by what the DUT actually requested.
    bit          rom_resp;
    logic [31:0] rom_addr;

    int checks;
    int passed;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic cycle(input bit rst, input bit rrdy, input bit drdy,
                         input bit jmp, input logic [31:0] ja, input bit idle_v);
        bit          e_iv, e_sv, pop, acc, dut_acc;
        logic [31:0] dut_pc;
        rst_n              = rst;
        pc_receive_ready_i = rrdy;
        inst_ready_i       = drdy;
        jump_en_i          = jmp;
        jump_addr_i        = ja;
        if (rom_resp) begin
            inst_data_i  = rom_word(rom_addr);
            inst_valid_i = 1'b1;
        end else begin
            inst_data_i  = $urandom;
            inst_valid_i = idle_v;
        end
        #1;
        e_iv = rst && !jmp && (q.size() > 0);
        pop  = e_iv && drdy;
        e_sv = rst && !jmp && ((q.size() + int'(m_infl) - int'(pop)) < 2);
        if (m_known) begin
            check("send_valid", {31'b0, pc_send_valid_o}, {31'b0, e_sv});
            check("inst_valid", {31'b0, inst_valid_o}, {31'b0, e_iv});
            check("pc_o", pc_o, m_pc);
            if (e_iv) begin
                check("inst_addr", inst_addr_o, q[0][63:32]);
                check("inst_data", inst_o, q[0][31:0]);
            end
            if (m_in_reset) begin
                check("rst_inst_o", inst_o, 32'h0);
                check("rst_inst_addr", inst_addr_o, 32'h0);
            end
        end
        dut_acc = pc_send_valid_o && pc_receive_ready_i;
        dut_pc  = pc_o;
        @(posedge clk);
        rom_resp = dut_acc && rst;
        rom_addr = dut_pc;
        if (!rst) begin
            q.delete();
            m_pc       = RESET_PC;
            m_infl     = 1'b0;
            m_in_reset = 1'b1;
            m_known    = 1'b1;
        end else begin
            m_in_reset = 1'b0;
            if (jmp) begin
                q.delete();
                m_infl = 1'b0;
                m_pc   = {ja[31:2], 2'b00};
            end else begin
                if (pop) void'(q.pop_front());
                if (m_infl) q.push_back({m_infl_addr, rom_word(m_infl_addr)});
                acc = e_sv && rrdy;
                if (acc) begin
                    m_infl_addr = m_pc;
                    m_pc        = m_pc + 32'd4;
                end
                m_infl = acc;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks             = 0;
        passed             = 0;
        m_known            = 1'b0;
        m_in_reset         = 1'b0;
        m_infl             = 1'b0;
        m_infl_addr        = '0;
        m_pc               = RESET_PC;
        rom_resp           = 1'b0;
        rom_addr           = '0;
        rst_n              = 1'b0;
        pc_receive_ready_i = 1'b0;
        inst_ready_i       = 1'b0;
        jump_en_i          = 1'b0;
        jump_addr_i        = '0;
        inst_data_i        = '0;
        inst_valid_i       = 1'b0;
        @(negedge clk);

        repeat (3)  cycle(0, 1, 1, 0, 32'h0, 1);   // reset
        repeat (10) cycle(1, 1, 1, 0, 32'h0, 1);   // streaming from RESET_PC
        repeat (5)  cycle(1, 1, 0, 0, 32'h0, 1);   // decode backpressure
        repeat (4)  cycle(1, 1, 1, 0, 32'h0, 1);
        repeat (3)  cycle(1, 0, 1, 0, 32'h0, 1);   // ROM stall with idle valid high
        repeat (4)  cycle(1, 1, 1, 0, 32'h0, 1);
        cycle(1, 1, 1, 1, 32'h0000_0103, 1);       // jump with work in flight
        repeat (6)  cycle(1, 1, 1, 0, 32'h0, 1);
        cycle(1, 1, 1, 1, 32'hFFFF_FFF8, 1);       // address wrap
        repeat (6)  cycle(1, 1, 1, 0, 32'h0, 1);
        repeat (4)  cycle(1, 1, 0, 0, 32'h0, 1);   // fill queue
        cycle(0, 1, 0, 0, 32'h0, 1);               // one-cycle reset mid-run
        repeat (6)  cycle(1, 1, 1, 0, 32'h0, 1);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 19) == 0),
                  $urandom,
                  1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
